// File: rtl/microwave_controller.sv
// Sequencing FSM for the BCD microwave countdown timer: keypad loads, 1 Hz tick, door/start/stop handling.
// Defining MICROWAVE_QUICK_START_EN adds the QUICK state (start on an empty timer loads 0:30 and cooks).
module microwave_controller #(
    parameter int CLK_DIV    = 50_000_000,
    parameter int DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       timer_load,
    output logic [3:0] timer_data,
    output logic       timer_en,
    output logic       timer_clear,
    output logic       mag_on,
    output logic       done_beep,
    output logic [2:0] state
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int DW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
`ifdef MICROWAVE_QUICK_START_EN
        ST_DONE  = 3'd4,
        ST_QUICK = 3'd5
`else
        ST_DONE  = 3'd4
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    digitCnt_q, digitCnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] doneCnt_q, doneCnt_d;
`ifdef MICROWAVE_QUICK_START_EN
    logic [1:0]    quickStep_q, quickStep_d;
`endif

    logic          timerLoad_q, timerLoad_d;
    logic [3:0]    timerData_q, timerData_d;
    logic          timerEn_q, timerEn_d;
    logic          timerClear_q, timerClear_d;
    logic          magOn_q, magOn_d;
    logic          doneBeep_q, doneBeep_d;

    logic keyOk;
    logic tick;
    logic startCook;

    assign keyOk     = key_valid && (key_digit <= 4'd9) && (digitCnt_q < 2'd3);
    assign tick      = (presc_q == PRESC_LAST);
    assign startCook = start && door_closed && !timer_zero;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            digitCnt_q   <= '0;
            presc_q      <= '0;
            doneCnt_q    <= '0;
`ifdef MICROWAVE_QUICK_START_EN
            quickStep_q  <= '0;
`endif
            timerLoad_q  <= 1'b0;
            timerData_q  <= '0;
            timerEn_q    <= 1'b0;
            timerClear_q <= 1'b0;
            magOn_q      <= 1'b0;
            doneBeep_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            digitCnt_q   <= digitCnt_d;
            presc_q      <= presc_d;
            doneCnt_q    <= doneCnt_d;
`ifdef MICROWAVE_QUICK_START_EN
            quickStep_q  <= quickStep_d;
`endif
            timerLoad_q  <= timerLoad_d;
            timerData_q  <= timerData_d;
            timerEn_q    <= timerEn_d;
            timerClear_q <= timerClear_d;
            magOn_q      <= magOn_d;
            doneBeep_q   <= doneBeep_d;
        end
    end

    // Within each state the branches follow event priority: door open, stop, start, key.
    always_comb begin
        state_d     = state_q;
        digitCnt_d  = digitCnt_q;
        presc_d     = presc_q;
        doneCnt_d   = doneCnt_q;
`ifdef MICROWAVE_QUICK_START_EN
        quickStep_d = quickStep_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    state_d = ST_IDLE;
`ifdef MICROWAVE_QUICK_START_EN
                end else if (start && door_closed && timer_zero) begin
                    state_d     = ST_QUICK;
                    quickStep_d = 2'd1;
`endif
                end else if (keyOk) begin
                    state_d    = ST_ENTRY;
                    digitCnt_d = digitCnt_q + 2'd1;
                end
            end
            ST_ENTRY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (startCook) begin
                    state_d = ST_COOK;
                    presc_d = '0;
                end else if (keyOk) begin
                    digitCnt_d = digitCnt_q + 2'd1;
                end
            end
            ST_COOK: begin
                if (!door_closed || stop) begin
                    state_d = ST_PAUSE;
                end else if (timer_zero) begin
                    state_d   = ST_DONE;
                    presc_d   = '0;
                    doneCnt_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                    presc_d = '0;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    presc_d = '0;
                    if (doneCnt_q == DONE_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        doneCnt_d = doneCnt_q + DW'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
`ifdef MICROWAVE_QUICK_START_EN
            ST_QUICK: begin
                if (!door_closed || stop) begin
                    state_d = ST_IDLE;
                end else if (quickStep_q == 2'd2) begin
                    state_d = ST_COOK;
                    presc_d = '0;
                end else begin
                    quickStep_d = quickStep_q + 2'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_IDLE) begin
            digitCnt_d = '0;
        end
    end

    always_comb begin
        timerLoad_d  = 1'b0;
        timerData_d  = '0;
        timerEn_d    = 1'b0;
        timerClear_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    timerClear_d = 1'b1;
`ifdef MICROWAVE_QUICK_START_EN
                end else if (start && door_closed && timer_zero) begin
                    timerLoad_d = 1'b1;
`endif
                end else if (keyOk) begin
                    timerLoad_d = 1'b1;
                    timerData_d = key_digit;
                end
            end
            ST_ENTRY: begin
                if (stop) begin
                    timerClear_d = 1'b1;
                end else if (!startCook && keyOk) begin
                    timerLoad_d = 1'b1;
                    timerData_d = key_digit;
                end
            end
            ST_COOK: begin
                timerEn_d = door_closed && !stop && !timer_zero && tick;
            end
            ST_PAUSE: begin
                timerClear_d = stop;
            end
`ifdef MICROWAVE_QUICK_START_EN
            // QUICK shifts in 0, 3, 0 so the timer reads 0:30 when COOK begins.
            ST_QUICK: begin
                if (!door_closed || stop) begin
                    timerClear_d = 1'b1;
                end else begin
                    timerLoad_d = 1'b1;
                    timerData_d = (quickStep_q == 2'd1) ? 4'd3 : 4'd0;
                end
            end
`endif
            default: begin
                timerLoad_d = 1'b0;
            end
        endcase
        magOn_d    = (state_d == ST_COOK);
        doneBeep_d = (state_d == ST_DONE);
    end

    assign timer_load  = timerLoad_q;
    assign timer_data  = timerData_q;
    assign timer_en    = timerEn_q;
    assign timer_clear = timerClear_q;
    assign mag_on      = magOn_q;
    assign done_beep   = doneBeep_q;
    assign state       = state_q;

endmodule

// File: tb/tb_microwave_controller.sv
// Bench for microwave_controller: directed front-panel scenarios then random traffic, checked every
// cycle against a cycle-count based behavioural model, with a BCD timer stand-in closing the loop.
module tb_microwave_controller;

    localparam int CD = 4;
    localparam int DT = 3;
`ifdef MICROWAVE_QUICK_START_EN
    localparam bit QUICK_ON = 1'b1;
`else
    localparam bit QUICK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       timer_zero;
    logic       timer_load;
    logic [3:0] timer_data;
    logic       timer_en;
    logic       timer_clear;
    logic       mag_on;
    logic       done_beep;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    bit checkOn = 1'b0;
    bit doorLvl = 1'b1;

    int tMin = 0, tTen = 0, tOne = 0;
    int mState = 0, digits = 0, cookCycles = 0, doneCycles = 0, qStep = 0;
    int eLoad = 0, eData = 0, eEn = 0, eClr = 0;
    bit prevDoor = 1'b1;
    int quickSeq[3] = '{0, 3, 0};

    int loadLog[$];
    int enTotal = 0;

    microwave_controller #(.CLK_DIV(CD), .DONE_TICKS(DT)) dut (
        .clk(clk), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
        .timer_load(timer_load), .timer_data(timer_data), .timer_en(timer_en),
        .timer_clear(timer_clear), .mag_on(mag_on), .done_beep(done_beep), .state(state)
    );

    always #5 clk = ~clk;

    // Stand-in for the BCD timer the controller drives.
    assign timer_zero = (tMin == 0) && (tTen == 0) && (tOne == 0);
    always @(posedge clk) begin
        if (clear || timer_clear === 1'b1) begin
            tMin <= 0; tTen <= 0; tOne <= 0;
        end else if (timer_load === 1'b1) begin
            tMin <= tTen; tTen <= tOne; tOne <= int'(timer_data);
        end else if (timer_en === 1'b1 && !timer_zero) begin
            if (tOne > 0) tOne <= tOne - 1;
            else if (tTen > 0) begin tTen <= tTen - 1; tOne <= 9; end
            else begin tMin <= tMin - 1; tTen <= 5; tOne <= 9; end
        end
    end

    // Reference: tracks mode plus elapsed cycles in COOK/DONE; ticks fall on multiples of CD.
    always @(posedge clk) begin
        bit keyOk;
        eLoad = 0; eData = 0; eEn = 0; eClr = 0;
        prevDoor = door_closed;
        keyOk = key_valid && (key_digit <= 9) && (digits < 3);
        if (clear) begin
            mState = 0; digits = 0; cookCycles = 0; doneCycles = 0; qStep = 0;
        end else if (mState == 0) begin
            if (stop) eClr = 1;
            else if (QUICK_ON && start && door_closed && timer_zero) begin
                mState = 5; qStep = 1; eLoad = 1; eData = quickSeq[0];
            end else if (keyOk) begin
                eLoad = 1; eData = int'(key_digit); digits++; mState = 1;
            end
        end else if (mState == 1) begin
            if (stop) begin eClr = 1; mState = 0; end
            else if (start && door_closed && !timer_zero) begin mState = 2; cookCycles = 0; end
            else if (keyOk) begin eLoad = 1; eData = int'(key_digit); digits++; end
        end else if (mState == 2) begin
            if (!door_closed || stop) mState = 3;
            else if (timer_zero) begin mState = 4; doneCycles = 0; end
            else begin
                cookCycles++;
                if (cookCycles % CD == 0) eEn = 1;
            end
        end else if (mState == 3) begin
            if (stop) begin eClr = 1; mState = 0; end
            else if (start && door_closed) begin mState = 2; cookCycles = 0; end
        end else if (mState == 4) begin
            if (stop) mState = 0;
            else begin
                doneCycles++;
                if (doneCycles == DT * CD) mState = 0;
            end
        end else begin
            if (!door_closed || stop) begin eClr = 1; mState = 0; end
            else begin
                eLoad = 1; eData = quickSeq[qStep]; qStep++;
                if (qStep == 3) begin mState = 2; cookCycles = 0; end
            end
        end
        if (mState == 0) digits = 0;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic compareLoop();
        forever begin
            @(negedge clk);
            if (checkOn) begin
                checkOutput("state", int'(state), mState);
                checkOutput("timer_load", int'(timer_load), eLoad);
                checkOutput("timer_data", int'(timer_data), eData);
                checkOutput("timer_en", int'(timer_en), eEn);
                checkOutput("timer_clear", int'(timer_clear), eClr);
                checkOutput("mag_on", int'(mag_on), (mState == 2) ? 1 : 0);
                checkOutput("done_beep", int'(done_beep), (mState == 4) ? 1 : 0);
                checkOutput("en_load_exclusive", int'(timer_en & timer_load), 0);
                checkOutput("mag_after_door_open", int'(mag_on & !prevDoor), 0);
                if (timer_load) loadLog.push_back(int'(timer_data));
                if (timer_en) enTotal++;
            end
        end
    endtask

    task automatic applyStimulus(input bit kv, input int kd, input bit st, input bit sp, input bit cl);
        @(negedge clk);
        key_valid   = kv;
        key_digit   = kd[3:0];
        start       = st;
        stop        = sp;
        door_closed = doorLvl;
        clear       = cl;
    endtask

    task automatic quiet(input int n);
        repeat (n) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic waitState(input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            quiet(1); #1;
            if (int'(state) == target) begin ok = 1'b1; break; end
        end
        if (!ok) checkOutput("wait_state_timeout", int'(state), target);
    endtask

    function automatic int logAt(input int idx);
        if (idx < loadLog.size()) return loadLog[idx];
        return -1;
    endfunction

    initial begin
        int base, cnt, kd;
        bit kv, st, sp, cl;
        key_valid = 0; key_digit = 0; start = 0; stop = 0; door_closed = 1; clear = 1;
        fork
            compareLoop();
        join_none
        @(posedge clk);
        checkOn = 1'b1;
        @(negedge clk); #1;
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_mag_on", int'(mag_on), 0);
        checkOutput("reset_load", int'(timer_load), 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Entry 1,3,0 then start.
        base = loadLog.size();
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        quiet(1);
        applyStimulus(0, 0, 1, 0, 0);
        quiet(1); #1;
        checkOutput("entry_load_count", loadLog.size() - base, 3);
        checkOutput("entry_data0", logAt(base), 1);
        checkOutput("entry_data1", logAt(base + 1), 3);
        checkOutput("entry_data2", logAt(base + 2), 0);
        checkOutput("entry_timer", tMin * 100 + tTen * 10 + tOne, 130);
        checkOutput("entry_state_cook", int'(state), 2);
        checkOutput("entry_mag_on", int'(mag_on), 1);
        base = enTotal;
        quiet(8); #1;
        checkOutput("cook_ticks_in_8", enTotal - base, 2);

        // Clear mid-COOK.
        applyStimulus(0, 0, 0, 0, 1);
        quiet(1); #1;
        checkOutput("clear_state", int'(state), 0);
        checkOutput("clear_mag_on", int'(mag_on), 0);
        checkOutput("clear_outputs", int'({timer_load, timer_en, timer_clear, done_beep, timer_data}), 0);

        // Countdown from 0:02.
        applyStimulus(1, 2, 0, 0, 0);
        quiet(1);
        applyStimulus(0, 0, 1, 0, 0);
        quiet(1); #1;
        checkOutput("count_state_cook", int'(state), 2);
        base = enTotal;
        waitState(4, 40);
        checkOutput("count_en_pulses", enTotal - base, 2);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_beep) cnt++;
            if (state == 3'd0) break;
            quiet(1); #1;
        end
        checkOutput("done_beep_cycles", cnt, DT * CD);
        checkOutput("done_to_idle", int'(state), 0);

        // Door open during COOK at 0:45, then resume.
        applyStimulus(1, 4, 0, 0, 0);
        applyStimulus(1, 5, 0, 0, 0);
        quiet(1);
        applyStimulus(0, 0, 1, 0, 0);
        quiet(1); #1;
        checkOutput("door_cook", int'(state), 2);
        quiet(5);
        doorLvl = 1'b0;
        quiet(1);
        quiet(1); #1;
        checkOutput("door_mag_off", int'(mag_on), 0);
        checkOutput("door_pause", int'(state), 3);
        base = enTotal;
        quiet(10); #1;
        checkOutput("door_no_ticks", enTotal - base, 0);
        doorLvl = 1'b1;
        applyStimulus(0, 0, 1, 0, 0);
        quiet(1); #1;
        checkOutput("resume_cook", int'(state), 2);
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            quiet(1); #1;
            if (timer_en) begin cnt = i; break; end
        end
        checkOutput("resume_first_tick", cnt, CD);

        // Start with door open in PAUSE stays paused; stop then returns to IDLE.
        applyStimulus(0, 0, 0, 1, 0);
        quiet(1); #1;
        checkOutput("stop_to_pause", int'(state), 3);
        doorLvl = 1'b0;
        applyStimulus(0, 0, 1, 0, 0);
        doorLvl = 1'b1;
        quiet(1); #1;
        checkOutput("prio_door_over_start", int'(state), 3);
        applyStimulus(0, 0, 0, 1, 0);
        quiet(1); #1;
        checkOutput("pause_stop_clear", int'(timer_clear), 1);
        checkOutput("pause_stop_idle", int'(state), 0);

        // Entry limits: 5, 12, 9, 9, 9.
        quiet(1);
        base = loadLog.size();
        applyStimulus(1, 5, 0, 0, 0);
        applyStimulus(1, 12, 0, 0, 0);
        applyStimulus(1, 9, 0, 0, 0);
        applyStimulus(1, 9, 0, 0, 0);
        applyStimulus(1, 9, 0, 0, 0);
        quiet(1); #1;
        checkOutput("limit_load_count", loadLog.size() - base, 3);
        checkOutput("limit_data0", logAt(base), 5);
        checkOutput("limit_data1", logAt(base + 1), 9);
        checkOutput("limit_data2", logAt(base + 2), 9);
        checkOutput("limit_state_entry", int'(state), 1);
        applyStimulus(0, 0, 0, 1, 0);
        quiet(1); #1;
        checkOutput("entry_stop_clear", int'(timer_clear), 1);
        checkOutput("entry_stop_idle", int'(state), 0);

        // Start in IDLE on an empty timer.
        quiet(2);
        base = loadLog.size();
        applyStimulus(0, 0, 1, 0, 0);
        quiet(4); #1;
`ifdef MICROWAVE_QUICK_START_EN
        checkOutput("quick_load_count", loadLog.size() - base, 3);
        checkOutput("quick_data0", logAt(base), 0);
        checkOutput("quick_data1", logAt(base + 1), 3);
        checkOutput("quick_data2", logAt(base + 2), 0);
        checkOutput("quick_timer", tMin * 100 + tTen * 10 + tOne, 30);
        checkOutput("quick_state_cook", int'(state), 2);
`else
        checkOutput("no_quick_loads", loadLog.size() - base, 0);
        checkOutput("no_quick_state", int'(state), 0);
`endif

        // Random front-panel traffic.
        for (int c = 0; c < 4000; c++) begin
            if (doorLvl) begin
                if ($urandom_range(0, 59) == 0) doorLvl = 1'b0;
            end else begin
                if ($urandom_range(0, 4) == 0) doorLvl = 1'b1;
            end
            kv = ($urandom_range(0, 3) == 0);
            kd = int'($urandom_range(0, 15));
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 49) == 0);
            cl = ($urandom_range(0, 699) == 0);
            applyStimulus(kv, kd, st, sp, cl);
        end
        quiet(2); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/microwave_controller.md
Name: microwave_controller

Overview:
- Sequencing FSM for the microwave countdown timer (mins : sec_tens : sec_ones, BCD).
- Converts keypad digits into single-cycle load pulses; the timer shifts each loaded digit ones→tens→mins.
- Generates the 1 Hz count-enable from the system clock, gates the magnetron, and handles door, start and stop events.
- Sits between the front-panel inputs and the timer; drives all of the timer's control inputs.

Parameters:
- CLK_DIV, 50_000_000, clk cycles per timer tick (1 s); legal range ≥2.
- DONE_TICKS, 3, ticks that done_beep stays high after countdown completes.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- key_valid  in  1  one-cycle strobe: key_digit is valid.
- key_digit  in  4  BCD digit; values 10–15 are ignored.
- start  in  1  start/resume request, level-sampled each cycle.
- stop  in  1  pause/cancel request, level-sampled each cycle.
- door_closed  in  1  1 = door closed.
- timer_zero  in  1  timer reads 0:00.
- timer_load  out  1  one-cycle load pulse to the timer.
- timer_data  out  4  digit presented to the timer with timer_load.
- timer_en  out  1  one-cycle countdown enable, one pulse per tick.
- timer_clear  out  1  one-cycle clear pulse to the timer.
- mag_on  out  1  magnetron enable.
- done_beep  out  1  high during DONE.
- state  out  3  current state code, for debug.

Behaviour:
- Reset (clear=1): state=IDLE(0). All outputs 0. Digit count=0, prescaler=0, DONE counter=0. clear has priority over every other input.
- State codes: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4, QUICK=5 (QUICK exists only with the optional feature).
- All outputs are registered. An event sampled at edge N produces its output effect in cycle N+1.
- Event priority when several occur in the same cycle: door open > stop > start > key.
- Keys:
  - In IDLE or ENTRY, a key_valid with key_digit≤9 while fewer than 3 digits are held causes timer_load=1 and timer_data=key_digit next cycle, increments the digit count, and moves to ENTRY.
  - The 4th and later digits, digits >9, and keys in any other state are ignored (no load pulse).
- IDLE:
  - stop → timer_clear pulse.
  - start is ignored unless the QUICK feature is compiled in.
- ENTRY:
  - start with door_closed=1 and timer_zero=0 → COOK.
  - start with timer_zero=1 (e.g. only zeros entered) → stays in ENTRY.
  - stop → timer_clear pulse, digit count=0, → IDLE.
- COOK:
  - mag_on=1 throughout.
  - The prescaler counts 0..CLK_DIV-1 and is reset to 0 on every entry into COOK.
  - At prescaler=CLK_DIV-1, emit one timer_en pulse if timer_zero=0.
  - timer_zero=1 → DONE, mag_on=0 next cycle, no further timer_en.
  - door_closed=0 → PAUSE.
  - stop → PAUSE.
- PAUSE:
  - mag_on=0. Prescaler frozen, then reset on resume.
  - start with door_closed=1 → COOK.
  - stop → timer_clear pulse, → IDLE.
- DONE:
  - done_beep=1.
  - Internal ticks from the same prescaler; after DONE_TICKS ticks → IDLE with done_beep=0.
  - stop → IDLE immediately.
  - Keys are ignored.
- Invariants:
  - timer_en and timer_load are never asserted in the same cycle.
  - mag_on is never 1 when door_closed was 0 in the previous cycle.
- Digit count resets on every transition into IDLE.

Optional Feature:
- Macro: MICROWAVE_QUICK_START_EN.
- Defined: start in IDLE with door_closed=1 and timer_zero=1 → QUICK.
  - QUICK emits three load pulses on consecutive cycles with timer_data 0, 3, 0, giving the timer 0:30.
  - Then → COOK automatically.
  - stop or door open during QUICK aborts: timer_clear pulse, → IDLE.
- Undefined: no QUICK state; start in IDLE has no effect.

Test Plan:
- Entry: CLK_DIV=4; keys 1, 3, 0 then start → three timer_load pulses with timer_data 1, 3, 0; the timer reads 1:30; state=2; a timer_en pulse every 4 cycles; mag_on=1.
- Countdown end: timer loaded with 0:02, start → exactly 2 timer_en pulses, then state=4 and done_beep=1 for DONE_TICKS×CLK_DIV cycles, then state=0.
- Door: during COOK at 0:45, door_closed=0 → mag_on=0 next cycle, state=3, no timer_en. Door closed plus start → resumes; first timer_en arrives CLK_DIV cycles later.
- Entry limits: keys 5, 12, 9, 9, 9 → only three load pulses (5, 9, 9). stop in ENTRY → timer_clear pulse, state=0.
- Priority and reset: start and door-open in the same cycle in PAUSE → stays in PAUSE. clear asserted mid-COOK → all outputs 0 and state=0 next cycle.
- MICROWAVE_QUICK_START_EN defined: start in IDLE with timer_zero=1 → loads 0, 3, 0, then state=2. Undefined: the same stimulus leaves state=0.
